// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller: time-multiplexed scan stage for an 8-digit
// seven-segment display. Holds a double-buffered 32-bit hex value plus
// per-digit decimal-point flags, steps through the digits every CLK_DIV
// clocks and presents the active digit index, nibble and DP level.
// New values are committed only at a frame boundary (digit 7 -> 0).
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the most significant nonzero nibble of the
//   display buffer are blanked unless their DP flag is set; digit 0 is
//   never blanked by this rule.
module sseg_scan_controller #(
    parameter int CLK_DIV = 100000,
    parameter int DIGITS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic        load,
    input  logic [7:0]  digit_en,
    output logic [2:0]  active_digit,
    output logic [3:0]  num,
    output logic        dp_ctrl,
    output logic        blank,
    output logic        frame_done,
    output logic        pending
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

    logic [CNT_W-1:0] presc;
    logic [2:0]       idx;
    logic [31:0]      disp_val;
    logic [7:0]       disp_dp;
    logic [31:0]      pend_val;
    logic [7:0]       pend_dp;
    logic             tick_p0;
    logic             boundary_p0;
    logic             dp_n_p1;
    logic             lz_blank_p1;

`ifdef LEADING_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the value is 0
    // so that a zero value still shows a single "0" on digit 0.
    function automatic logic [2:0] msd_nibble(input logic [31:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction
`endif

    // Slot tick at the end of each digit slot; frame boundary on the last digit.
    always_comb begin
        tick_p0     = (presc == CNT_LAST);
        boundary_p0 = tick_p0 && (idx == IDX_LAST);
    end

    // Prescaler and digit index: each digit slot lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= 3'd0;
        end else begin
            if (tick_p0) begin
                presc <= '0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Double buffer: loads park in the pending buffer and commit at the frame
    // boundary; a load on the boundary itself goes straight to the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_val <= 32'h0;
            disp_dp  <= 8'h0;
            pend_val <= 32'h0;
            pend_dp  <= 8'h0;
            pending  <= 1'b0;
        end else if (boundary_p0) begin
            if (load) begin
                disp_val <= value;
                disp_dp  <= dp_in;
            end else if (pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pending  <= 1'b1;
        end
    end

    // ---- stage p1: registered digit outputs, one cycle behind the index ----
    always_ff @(posedge clk) begin
        if (reset) begin
            active_digit <= 3'd0;
            num          <= 4'h0;
            dp_n_p1      <= 1'b1;
            lz_blank_p1  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            active_digit <= idx;
            num          <= disp_val[{idx, 2'b00} +: 4];
            dp_n_p1      <= ~disp_dp[idx];
`ifdef LEADING_ZERO_BLANK_EN
            lz_blank_p1  <= (idx > msd_nibble(disp_val)) && !disp_dp[idx];
`else
            lz_blank_p1  <= 1'b0;
`endif
            frame_done   <= boundary_p0;
        end
    end

    // Blanking follows the registered digit; a dark digit never lights its DP.
    always_comb begin
        blank   = ~digit_en[active_digit] | lz_blank_p1;
        dp_ctrl = blank | dp_n_p1;
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed self-checking bench for sseg_scan_controller (CLK_DIV = 4).
// Loads are pushed to a scoreboard queue when driven and popped into the
// expected display image at each frame boundary; every cycle the outputs
// are compared against that image and the expected scan position.
module tb_sseg_scan_controller;

    localparam int CD = 4;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  d;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic        load;
    logic [7:0]  digit_en;
    logic [2:0]  active_digit;
    logic [3:0]  num;
    logic        dp_ctrl;
    logic        blank;
    logic        frame_done;
    logic        pending;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    frame_t      q[$];
    logic [31:0] m_disp   = 32'h0;
    logic [7:0]  m_dp     = 8'h0;

    sseg_scan_controller #(.CLK_DIV(CD), .DIGITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .value        (value),
        .dp_in        (dp_in),
        .load         (load),
        .digit_en     (digit_en),
        .active_digit (active_digit),
        .num          (num),
        .dp_ctrl      (dp_ctrl),
        .blank        (blank),
        .frame_done   (frame_done),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] top_nz(input logic [31:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) r = 3'(i);
        return r;
    endfunction

    // One clock edge, then compare every output with the expected state.
    task automatic step();
        logic [2:0] e_act;
        logic [3:0] e_num;
        logic       e_dpn, e_lz, e_fd, e_blank, e_pend;
        e_act = 3'((cyc / CD) % 8);
        e_num = m_disp[4*e_act +: 4];
        e_dpn = ~m_dp[e_act];
        e_lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        e_lz  = (e_act > top_nz(m_disp)) && !m_dp[e_act];
`endif
        @(posedge clk);
        #1;
        if (reset) begin
            cyc    = 0;
            q.delete();
            m_disp = 32'h0;
            m_dp   = 8'h0;
            e_act  = 3'd0;
            e_num  = 4'h0;
            e_dpn  = 1'b1;
            e_lz   = 1'b0;
            e_fd   = 1'b0;
        end else begin
            cyc++;
            e_fd = ((cyc % (8 * CD)) == 0);
            if (e_fd && q.size() != 0) begin
                m_disp = q[0].v;
                m_dp   = q[0].d;
                void'(q.pop_front());
            end
        end
        e_pend  = (q.size() != 0);
        e_blank = ~digit_en[e_act] | e_lz;
        chk("active_digit", 32'(active_digit), 32'(e_act));
        chk("num",          32'(num),          32'(e_num));
        chk("blank",        32'(blank),        32'(e_blank));
        chk("dp_ctrl",      32'(dp_ctrl),      32'(e_blank | e_dpn));
        chk("frame_done",   32'(frame_done),   32'(e_fd));
        chk("pending",      32'(pending),      32'(e_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Single-cycle load strobe; a second load before commit replaces the first.
    task automatic do_load(input logic [31:0] v, input logic [7:0] d);
        frame_t e;
        e.v = v;
        e.d = d;
        if (q.size() != 0) void'(q.pop_back());
        q.push_back(e);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Advance until the current (pre-edge) digit index equals d.
    task automatic goto_digit(input int d);
        for (int i = 0; i < 8 * CD && ((cyc / CD) % 8) != d; i++) step();
    endtask

    // Advance until the next edge is a frame boundary.
    task automatic goto_boundary();
        for (int i = 0; i < 8 * CD && (cyc % (8 * CD)) != (8 * CD - 1); i++) step();
    endtask

    initial begin
        reset    = 1'b1;
        value    = 32'h0;
        dp_in    = 8'h0;
        load     = 1'b0;
        digit_en = 8'hFF;
        run(2);
        reset = 1'b0;

        // Free-running scan over a full frame and past the wrap.
        run(36);

        // Mid-frame load at digit 3: held pending until the wrap.
        goto_digit(3);
        do_load(32'h12345678, 8'h04);
        run(8 * CD * 2);

        // Two loads before the wrap: last write wins.
        goto_digit(2);
        do_load(32'hAAAAAAAA, 8'h00);
        run(5);
        do_load(32'h0000BEEF, 8'h00);
        run(8 * CD * 2);

        // Load on the boundary tick bypasses the pending buffer.
        goto_boundary();
        do_load(32'hCAFEF00D, 8'h80);
        run(8 * CD + 4);

        // Digit 0 disabled while its DP is requested; small value for
        // leading-zero blanking builds.
        digit_en = 8'b1111_1110;
        goto_digit(4);
        do_load(32'h000000A5, 8'h01);
        run(8 * CD * 2);
        digit_en = 8'hFF;
        run(8 * CD);

        // Reset at digit 5 with a load pending.
        goto_digit(3);
        do_load(32'h87654321, 8'hF0);
        goto_digit(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(8 * CD + 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
